wb_queue_unit: RTL and testbench
================================

// Module: wb_queue_unit
// PURPOSE
//  Writeback stage for the CPU. It buffers decoded {data, addr, opcode} results from
//  execute in a DEPTH-entry FIFO and retires them in order to one of two targets:
//  the GPR file (single-cycle write) or RAM (request/grant handshake).
//  It replaces the pause/data_read coupling with valid/ready, adds a RAM grant
//  timeout, a flush and status outputs. Outputs are never tri-stated.
// PARAMETERS
//  DATA_W      14  data width
//  ADDR_W      12  address width (GPR and RAM)
//  OP_W         4  opcode width
//  DEPTH        4  FIFO entries, power of 2, >=2
//  TIMEOUT_CYC 16  cycles to wait for ram_grant before dropping; 0 = wait forever
// PORTS
//  clk          in   1                  rising-edge clock
//  reset_n      in   1                  asynchronous, active-low reset
//  in_valid     in   1                  execute presents an entry
//  in_data      in   DATA_W+ADDR_W+OP_W {data, addr, opcode}, opcode in LSBs
//  in_ready     out  1                  = !full; push when in_valid&&in_ready
//  flush        in   1                  sync: discard queue and in-flight op
//  gpr_wr       out  1                  one-cycle GPR write strobe
//  gpr_data     out  DATA_W             GPR write data
//  gpr_addr     out  ADDR_W             GPR write address
//  ram_wr       out  1                  RAM write request, held until grant
//  ram_grant    in   1                  RAM accepts the request this cycle
//  ram_data     out  DATA_W             RAM write data
//  ram_addr     out  ADDR_W             RAM write address
//  q_count      out  $clog2(DEPTH)+1    occupied entries
//  q_empty      out  1                  q_count==0 and FSM in IDLE
//  err_timeout  out  1                  one-cycle pulse when RAM entry dropped
//  err_badop    out  1                  one-cycle pulse when unknown opcode dropped
// BEHAVIOUR
//  Reset: all outputs 0 except in_ready=1 and q_empty=1. FIFO pointers 0, FSM IDLE,
//   timeout counter 0.
//  Classification of head opcode: OP_MOV_SR/OP_MOV_BIO/OP_INC_BIO -> RAM;
//   OP_MOV_SA/OP_INC_SR -> GPR; anything else -> BAD.
//  FSM states: IDLE, GPR_WR, RAM_WAIT.
//   IDLE, queue non-empty: pop head. GPR -> GPR_WR with gpr_data/addr registered.
//    RAM -> RAM_WAIT with ram_wr=1 and ram_data/addr registered. BAD -> stay IDLE
//    and pulse err_badop next cycle.
//   GPR_WR: gpr_wr=1 for exactly this cycle -> IDLE.
//   RAM_WAIT: ram_wr, ram_addr and ram_data are held stable. ram_grant=1 -> IDLE
//    with ram_wr=0 next cycle. Counter reaching TIMEOUT_CYC without a grant ->
//    drop the entry, pulse err_timeout, go IDLE.
//  Latency: with an empty queue, a push at edge T gives gpr_wr or ram_wr high
//   after edge T+2. Throughput is one GPR write every 2 cycles, with one IDLE bubble.
//  Data outputs hold their last value when strobes are low; only strobes are
//   qualifying.
//  Full: in_ready=0. A push is refused even if a pop happens in the same cycle.
//  Empty: the FSM stays IDLE and all strobes stay 0.
//  Push and pop in the same cycle: the count is unchanged. Pointers wrap modulo DEPTH.
//  Flush: at the next edge, pointers are cleared, FSM goes IDLE and strobes go 0.
//   A push in the flush cycle is dropped. ram_grant in the flush cycle means the
//   RAM write has completed; no error is raised. err_* pulses are not generated.
//  Reset mid-operation (asynchronous): strobes drop immediately. A held ram_wr is
//   abandoned; the RAM side must tolerate a withdrawn request.
//  err_* pulses never coincide with a strobe for the same entry.
// STRUCTURE
//  Shared package: opcodes.v supplies the OP_* defines. Add WB_ST_* state encodings
//   and a WB_TGT_{GPR,RAM,BAD} classify macro there.
//  Sub-module: wb_fifo (parameters W, DEPTH) with push/pop/full/empty/count and a
//   registered head. The FSM and timeout counter stay in the top level.
// TESTING
//  1 Push OP_MOV_SA, data 14'h0ABC, addr 12'h005 -> gpr_wr for 1 cycle at T+2 with
//    0ABC/005; q_empty=1 afterwards.
//  2 Push OP_MOV_SR to addr 12'h100, hold ram_grant=0 for 5 cycles then 1 ->
//    ram_wr high for 6 cycles with stable 12'h100, low the next cycle.
//  3 Push DEPTH+1 entries back-to-back with ram_grant=0 -> in_ready drops after
//    DEPTH accepted; q_count=DEPTH, the extra entry is not accepted.
//  4 RAM op with no grant and TIMEOUT_CYC=16 -> err_timeout pulse after 16 wait
//    cycles; the next queued GPR op retires normally.
//  5 Push opcode 4'hF then OP_INC_SR -> one err_badop pulse, then one gpr_wr; no
//    ram_wr.
//  6 Queue 3 entries with ram_wr held, assert flush with ram_grant=1 -> next cycle
//    strobes 0, q_count=0, no err pulses. Async reset mid-RAM_WAIT -> ram_wr=0
//    immediately.

Source files
------------

// File: rtl/wb_queue_unit_pkg.sv
// Shared definitions for the writeback queue unit.
//   - default datapath widths
//   - OP_* opcode values
//   - WB_ST_* FSM state encodings
//   - WB_TGT_* retirement targets and the opcode classifier
package wb_queue_unit_pkg;

  localparam int WB_DATA_W = 14;
  localparam int WB_ADDR_W = 12;
  localparam int WB_OP_W   = 4;

  typedef logic [WB_OP_W-1:0] opcode_t;

  localparam opcode_t OP_MOV_SA  = 4'h1;
  localparam opcode_t OP_MOV_SR  = 4'h2;
  localparam opcode_t OP_MOV_BIO = 4'h3;
  localparam opcode_t OP_INC_SR  = 4'h4;
  localparam opcode_t OP_INC_BIO = 4'h5;

  typedef enum logic [1:0] {
    WB_ST_IDLE     = 2'd0,
    WB_ST_GPR_WR   = 2'd1,
    WB_ST_RAM_WAIT = 2'd2
  } wb_state_e;

  typedef enum logic [1:0] {
    WB_TGT_GPR = 2'd0,
    WB_TGT_RAM = 2'd1,
    WB_TGT_BAD = 2'd2
  } wb_tgt_e;

  // Where a queued entry retires; unknown opcodes are dropped as BAD.
  function automatic wb_tgt_e wb_classify(input opcode_t op);
    case (op)
      OP_MOV_SR, OP_MOV_BIO, OP_INC_BIO: return WB_TGT_RAM;
      OP_MOV_SA, OP_INC_SR:              return WB_TGT_GPR;
      default:                           return WB_TGT_BAD;
    endcase
  endfunction

endpackage

// File: rtl/wb_queue_unit_if.sv
// Writeback bus bundle: execute-side push handshake plus GPR and RAM write ports.
//   master : environment view (execute stage, GPR file, RAM)
//   slave  : writeback unit view
interface wb_queue_unit_if #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 12,
  parameter int OP_W   = 4
);
  logic                           in_valid;
  logic [DATA_W+ADDR_W+OP_W-1:0]  in_data;   // {data, addr, opcode}
  logic                           in_ready;
  logic                           gpr_wr;
  logic [DATA_W-1:0]              gpr_data;
  logic [ADDR_W-1:0]              gpr_addr;
  logic                           ram_wr;
  logic                           ram_grant;
  logic [DATA_W-1:0]              ram_data;
  logic [ADDR_W-1:0]              ram_addr;

  modport master (
    output in_valid, in_data, ram_grant,
    input  in_ready, gpr_wr, gpr_data, gpr_addr, ram_wr, ram_data, ram_addr
  );

  modport slave (
    input  in_valid, in_data, ram_grant,
    output in_ready, gpr_wr, gpr_data, gpr_addr, ram_wr, ram_data, ram_addr
  );
endinterface

// File: rtl/wb_queue_unit_fifo.sv
// wb_fifo: DEPTH-entry queue with a registered head.
//   push/wr_data      : write when push && !full (ignored during flush)
//   pop               : consume the head; only honoured while head_valid
//   head_data/valid   : registered copy of the oldest entry, valid one edge
//                       after that entry is in the array and at the head
//   full/empty/count  : occupancy, count includes the head entry
//   flush             : synchronous clear of pointers and head
module wb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wr_data,
  output logic [W-1:0]           head_data,
  output logic                   head_valid,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [PW:0]   count_q, count_after_pop;
  logic          push_ok, pop_ok;

  assign full            = (count_q == DEPTH_C);
  assign empty           = (count_q == '0);
  assign count           = count_q;
  assign push_ok         = push && !full && !flush;
  assign pop_ok          = pop && head_valid && !flush;
  assign rd_ptr_nxt      = pop_ok ? rd_ptr + 1'b1 : rd_ptr;
  assign count_after_pop = count_q - {{PW{1'b0}}, pop_ok};

  // NOTE: the storage array has no reset; only entries covered by count are
  // ever read, so clearing it would cost flops and buy nothing.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr  <= rd_ptr_nxt;
      count_q <= count_q + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop_ok};
    end
  end

  // The head register tracks the entry that will be at rd_ptr after this edge.
  // An entry written at this same edge is not visible yet, which is what puts
  // one edge between a push and the head becoming valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_valid <= 1'b0;
      head_data  <= '0;
    end else if (flush) begin
      head_valid <= 1'b0;
    end else begin
      head_valid <= (count_after_pop != '0);
      head_data  <= mem[rd_ptr_nxt];
    end
  end

endmodule

// File: rtl/wb_queue_unit.sv
// wb_queue_unit: CPU writeback stage.
// Buffers {data, addr, opcode} entries from execute and retires them in order
// to the GPR file (one-cycle strobe) or RAM (request held until grant, dropped
// after TIMEOUT_CYC wait cycles; 0 waits forever).
//   clk, reset_n : clock, asynchronous active-low reset
//   flush        : synchronous discard of queue and in-flight operation
//   bus (slave)  : in_valid/in_data/in_ready, gpr_*, ram_wr/ram_grant/ram_*
//   q_count      : occupied queue entries
//   q_empty      : queue empty and FSM idle
//   err_timeout  : one-cycle pulse, RAM entry dropped for lack of grant
//   err_badop    : one-cycle pulse, entry with unknown opcode dropped
module wb_queue_unit
  import wb_queue_unit_pkg::*;
#(
  parameter int DATA_W      = WB_DATA_W,
  parameter int ADDR_W      = WB_ADDR_W,
  parameter int OP_W        = WB_OP_W,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  wb_queue_unit_if.slave         bus,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   q_empty,
  output logic                   err_timeout,
  output logic                   err_badop
);

  localparam int ENT_W = DATA_W + ADDR_W + OP_W;
  localparam int TW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYC - 1);

  wb_state_e         state_q, state_d;
  logic [ENT_W-1:0]  head_q;
  logic              head_valid, fifo_full, fifo_empty;
  logic [DATA_W-1:0] head_d;
  logic [ADDR_W-1:0] head_a;
  logic [OP_W-1:0]   head_op;
  wb_tgt_e           head_tgt;
  logic              pop, timeout_hit;
  logic [TW-1:0]     wait_cnt;
  logic [DATA_W-1:0] gpr_data_q, ram_data_q;
  logic [ADDR_W-1:0] gpr_addr_q, ram_addr_q;
  logic              gpr_wr_c, ram_wr_c;

  wb_fifo #(.W(ENT_W), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .push       (bus.in_valid),
    .pop        (pop),
    .wr_data    (bus.in_data),
    .head_data  (head_q),
    .head_valid (head_valid),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (q_count)
  );

  assign head_d   = head_q[ENT_W-1 -: DATA_W];
  assign head_a   = head_q[OP_W +: ADDR_W];
  assign head_op  = head_q[OP_W-1:0];
  assign head_tgt = wb_classify(opcode_t'(head_op));

  // The head is taken only from IDLE; BAD entries are consumed without
  // leaving IDLE so the next entry can be taken one cycle later.
  assign pop         = (state_q == WB_ST_IDLE) && head_valid && !flush;
  assign timeout_hit = (TIMEOUT_CYC != 0) && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= WB_ST_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: a default assignment ahead of the case keeps every path assigned,
  // so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = WB_ST_IDLE;
    end else begin
      case (state_q)
        WB_ST_IDLE: begin
          if (pop) begin
            case (head_tgt)
              WB_TGT_GPR: state_d = WB_ST_GPR_WR;
              WB_TGT_RAM: state_d = WB_ST_RAM_WAIT;
              default:    state_d = WB_ST_IDLE;
            endcase
          end
        end
        WB_ST_GPR_WR:   state_d = WB_ST_IDLE;
        WB_ST_RAM_WAIT: if (bus.ram_grant || timeout_hit) state_d = WB_ST_IDLE;
        default:        state_d = WB_ST_IDLE;
      endcase
    end
  end

  // Strobes come straight from the state register, so an asynchronous reset
  // withdraws them immediately.
  always_comb begin
    gpr_wr_c = 1'b0;
    ram_wr_c = 1'b0;
    case (state_q)
      WB_ST_GPR_WR:   gpr_wr_c = 1'b1;
      WB_ST_RAM_WAIT: ram_wr_c = 1'b1;
      default: ;
    endcase
  end

  // Data registers load only when an entry is dispatched and otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gpr_data_q  <= '0;
      gpr_addr_q  <= '0;
      ram_data_q  <= '0;
      ram_addr_q  <= '0;
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
      err_badop   <= 1'b0;
    end else begin
      if (pop && head_tgt == WB_TGT_GPR) begin
        gpr_data_q <= head_d;
        gpr_addr_q <= head_a;
      end
      if (pop && head_tgt == WB_TGT_RAM) begin
        ram_data_q <= head_d;
        ram_addr_q <= head_a;
      end
      // Counts completed wait cycles; zero whenever not waiting, so every
      // RAM entry starts its timeout window fresh.
      if (state_q == WB_ST_RAM_WAIT && !flush && !bus.ram_grant && !timeout_hit)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
      // A grant in the final wait cycle wins over the timeout; flush never
      // reports errors.
      err_timeout <= (state_q == WB_ST_RAM_WAIT) && !flush && !bus.ram_grant && timeout_hit;
      err_badop   <= pop && (head_tgt == WB_TGT_BAD);
    end
  end

  assign bus.in_ready = !fifo_full;
  assign bus.gpr_wr   = gpr_wr_c;
  assign bus.gpr_data = gpr_data_q;
  assign bus.gpr_addr = gpr_addr_q;
  assign bus.ram_wr   = ram_wr_c;
  assign bus.ram_data = ram_data_q;
  assign bus.ram_addr = ram_addr_q;
  assign q_empty      = fifo_empty && (state_q == WB_ST_IDLE);

endmodule

// File: tb/tb_wb_queue_unit.sv
// Self-checking bench for wb_queue_unit: a queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_wb_queue_unit;
  import wb_queue_unit_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] q_count;
  logic       q_empty, err_timeout, err_badop;

  wb_queue_unit_if #(.DATA_W(14), .ADDR_W(12), .OP_W(4)) bus ();

  wb_queue_unit #(.DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .bus         (bus),
    .q_count     (q_count),
    .q_empty     (q_empty),
    .err_timeout (err_timeout),
    .err_badop   (err_badop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [29:0] ent(input logic [13:0] d, input logic [11:0] a, input logic [3:0] op);
    return {d, a, op};
  endfunction

  // ---------------- reference model ----------------
  // Entries wait in a queue stamped with their push edge. The retire side is
  // either idle, writing a GPR, or waiting on RAM. An idle retire side takes
  // the oldest entry once it has been queued for at least two edges.
  typedef struct { logic [29:0] d; int c; } ent_t;
  ent_t        mq[$];
  ent_t        m_e;
  int          cyc = 0;
  int          m_busy = 0;   // 0 idle, 1 gpr, 2 ram
  int          m_wait = 0;
  bit          m_acc;
  logic        m_errt = 1'b0, m_errb = 1'b0;
  logic [13:0] m_gd = '0, m_rd = '0;
  logic [11:0] m_ga = '0, m_ra = '0;

  function automatic int target(input logic [3:0] op);
    if (op == OP_MOV_SA || op == OP_INC_SR) return 1;
    if (op == OP_MOV_SR || op == OP_MOV_BIO || op == OP_INC_BIO) return 2;
    return 0;
  endfunction

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      mq.delete();
      m_busy = 0; m_wait = 0; m_errt = 1'b0; m_errb = 1'b0;
      m_gd = '0; m_ga = '0; m_rd = '0; m_ra = '0;
    end else begin
      cyc++;
      m_errt = 1'b0;
      m_errb = 1'b0;
      m_acc  = bus.in_valid && (mq.size() < DEPTH);
      if (flush) begin
        mq.delete();
        m_busy = 0;
      end else begin
        if (m_busy == 1) begin
          m_busy = 0;
        end else if (m_busy == 2) begin
          if (bus.ram_grant) m_busy = 0;
          else if (m_wait + 1 == TIMEOUT) begin m_busy = 0; m_errt = 1'b1; end
          else m_wait++;
        end else if (mq.size() != 0 && mq[0].c + 2 <= cyc) begin
          m_e = mq.pop_front();
          case (target(m_e.d[3:0]))
            1: begin m_busy = 1; m_gd = m_e.d[29:16]; m_ga = m_e.d[15:4]; end
            2: begin m_busy = 2; m_wait = 0; m_rd = m_e.d[29:16]; m_ra = m_e.d[15:4]; end
            default: m_errb = 1'b1;
          endcase
        end
        if (m_acc) mq.push_back('{d: bus.in_data, c: cyc});
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      check("in_ready",    bus.in_ready, (mq.size() < DEPTH));
      check("q_count",     q_count, mq.size());
      check("q_empty",     q_empty, (mq.size() == 0 && m_busy == 0));
      check("gpr_wr",      bus.gpr_wr, (m_busy == 1));
      check("ram_wr",      bus.ram_wr, (m_busy == 2));
      check("err_timeout", err_timeout, m_errt);
      check("err_badop",   err_badop, m_errb);
      check("gpr_data",    bus.gpr_data, m_gd);
      check("gpr_addr",    bus.gpr_addr, m_ga);
      check("ram_data",    bus.ram_data, m_rd);
      check("ram_addr",    bus.ram_addr, m_ra);
    end
  end

  // Event counters for the directed scenarios.
  int n_gpr = 0, n_ram = 0, n_errt = 0, n_errb = 0;
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      n_gpr  += int'(bus.gpr_wr);
      n_ram  += int'(bus.ram_wr);
      n_errt += int'(err_timeout);
      n_errb += int'(err_badop);
    end
  end

  task automatic push(input logic [29:0] d);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  int b_gpr, b_ram, b_errt, b_errb;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.ram_grant = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_q_empty",  q_empty, 1);
    check("rst_q_count",  q_count, 0);
    check("rst_gpr_wr",   bus.gpr_wr, 0);
    check("rst_ram_wr",   bus.ram_wr, 0);
    check("rst_errs",     {err_timeout, err_badop}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single GPR write, strobe two edges after the push edge
    push(ent(14'h0ABC, 12'h005, OP_MOV_SA));
    idle();
    check("t1_not_yet", bus.gpr_wr, 0);
    @(negedge clk);
    check("t1_not_yet2", bus.gpr_wr, 0);
    @(negedge clk);
    check("t1_gpr_wr",   bus.gpr_wr, 1);
    check("t1_gpr_data", bus.gpr_data, 14'h0ABC);
    check("t1_gpr_addr", bus.gpr_addr, 12'h005);
    @(negedge clk);
    check("t1_gpr_drop", bus.gpr_wr, 0);
    check("t1_q_empty",  q_empty, 1);

    // 2: RAM write held six cycles, grant in the sixth
    push(ent(14'h1234, 12'h100, OP_MOV_SR));
    idle();
    @(negedge clk);
    @(negedge clk);
    for (int i = 1; i <= 6; i++) begin
      check("t2_ram_wr",   bus.ram_wr, 1);
      check("t2_ram_addr", bus.ram_addr, 12'h100);
      if (i == 6) bus.ram_grant = 1'b1;
      @(negedge clk);
    end
    bus.ram_grant = 1'b0;
    check("t2_ram_drop", bus.ram_wr, 0);
    @(negedge clk);
    check("t2_q_empty", q_empty, 1);

    // 3: RAM op stalls without grant; DEPTH+1 pushes fill the queue
    push(ent(14'h0011, 12'h200, OP_MOV_BIO));
    idle();
    b_gpr = n_gpr; b_ram = n_ram; b_errt = n_errt;
    @(negedge clk);
    @(negedge clk);
    check("t3_ram_held", bus.ram_wr, 1);
    for (int k = 0; k < DEPTH + 1; k++)
      push(ent(14'h0100 + k[13:0], 12'h010 + k[11:0], OP_MOV_SA));
    idle();
    check("t3_q_count_full", q_count, DEPTH);
    check("t3_in_ready_low", bus.in_ready, 0);

    // 4: timeout after 16 wait cycles, then queued GPR ops retire
    for (int i = 0; i < 40 && !err_timeout; i++) @(negedge clk);
    check("t4_timeout_seen", err_timeout, 1);
    check("t4_ram_off",      bus.ram_wr, 0);
    @(negedge clk);
    check("t4_ram_cycles",   n_ram - b_ram, TIMEOUT);
    check("t4_errt_count",   n_errt - b_errt, 1);
    check("t4_gpr_wr",       bus.gpr_wr, 1);
    check("t4_gpr_data",     bus.gpr_data, 14'h0100);
    check("t4_gpr_addr",     bus.gpr_addr, 12'h010);
    repeat (12) @(negedge clk);
    check("t4_gpr_total",    n_gpr - b_gpr, DEPTH);
    check("t4_q_empty",      q_empty, 1);

    // 5: bad opcode dropped, following GPR op retires
    b_gpr = n_gpr; b_ram = n_ram; b_errb = n_errb;
    push(ent(14'h0777, 12'h022, 4'hF));
    push(ent(14'h2AAA, 12'h033, OP_INC_SR));
    idle();
    repeat (8) @(negedge clk);
    check("t5_badop_count", n_errb - b_errb, 1);
    check("t5_gpr_count",   n_gpr - b_gpr, 1);
    check("t5_no_ram",      n_ram - b_ram, 0);
    check("t5_gpr_data",    bus.gpr_data, 14'h2AAA);

    // 6: flush with three queued entries, RAM request held and granted
    b_gpr = n_gpr; b_errt = n_errt; b_errb = n_errb;
    push(ent(14'h0055, 12'h300, OP_INC_BIO));
    for (int k = 0; k < 3; k++) push(ent(14'h0200 + k[13:0], 12'h040, OP_MOV_SA));
    @(negedge clk);
    check("t6_pre_ram_wr",  bus.ram_wr, 1);
    check("t6_pre_q_count", q_count, 3);
    bus.in_data   = ent(14'h3333, 12'h041, OP_MOV_SA);
    flush         = 1'b1;
    bus.ram_grant = 1'b1;
    @(negedge clk);
    flush = 1'b0; bus.ram_grant = 1'b0; bus.in_valid = 1'b0;
    check("t6_ram_wr",  bus.ram_wr, 0);
    check("t6_gpr_wr",  bus.gpr_wr, 0);
    check("t6_q_count", q_count, 0);
    check("t6_errs",    {err_timeout, err_badop}, 0);
    repeat (4) @(negedge clk);
    check("t6_no_err_later", (n_errt - b_errt) + (n_errb - b_errb), 0);
    check("t6_no_gpr",       n_gpr - b_gpr, 0);
    check("t6_q_empty",      q_empty, 1);

    // 6b: asynchronous reset while a RAM request is held
    push(ent(14'h0066, 12'h3FF, OP_MOV_SR));
    idle();
    @(negedge clk);
    @(negedge clk);
    check("t6b_ram_held", bus.ram_wr, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t6b_ram_drop", bus.ram_wr, 0);
    check("t6b_q_count",  q_count, 0);
    check("t6b_in_ready", bus.in_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    push(ent(14'h0099, 12'h007, OP_MOV_SA));
    idle();
    repeat (4) @(negedge clk);
    check("t6b_after_data", bus.gpr_data, 14'h0099);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
